// File: rtl/pulse_meas_ctrl_pkg.sv
// Shared types and defaults for the button pulse-duration measurement slice.
// Holds the FSM encoding and the default timing parameters.
package pulse_meas_ctrl_pkg;

   localparam int PM_CNT_W_DEF     = 15;
   localparam int PM_TICK_DIV_DEF  = 50_000;
   localparam int PM_DEB_TICKS_DEF = 20;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DEB_PRESS = 3'd1,
      ST_MEASURE   = 3'd2,
      ST_DEB_REL   = 3'd3,
      ST_DONE      = 3'd4
   } pm_state_t;

   // run counter advances on ticks only while a press is in progress
   function automatic logic pm_is_counting(pm_state_t s);
      return (s == ST_DEB_PRESS) ||
             (s == ST_MEASURE)   ||
             (s == ST_DEB_REL);
   endfunction

endpackage

// File: rtl/pulse_meas_ctrl_tick_gen.sv
// Measurement-tick prescaler: one tick every TICK_DIV clocks.
// restart realigns the phase so tick k lands k*TICK_DIV clocks later.
module pulse_tick_gen #(
   parameter int TICK_DIV = 50_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_pre;
   logic          w_last;

   assign w_last = (r_pre == LAST);

   // prescaler wraps at TICK_DIV-1, restart forces phase zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (restart) begin
         r_pre <= '0;
      end else if (w_last) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   assign tick = w_last;

endmodule

// File: rtl/pulse_meas_ctrl.sv
// Debounced button hold-time measurement feeding the LED colour stage.
// Publishes a saturating tick count with a one-cycle valid strobe.
module pulse_meas_ctrl
   import pulse_meas_ctrl_pkg::*;
#(
   parameter int TICK_DIV       = PM_TICK_DIV_DEF,
   parameter int DEBOUNCE_TICKS = PM_DEB_TICKS_DEF,
   parameter int CNT_W          = PM_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_in,
   input  logic             clear,
   output logic [CNT_W-1:0] cont_tiempo,
   output logic             meas_valid,
   output logic             busy,
   output logic             overflow
);

   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

   logic             r_sync1;
   logic             r_sync2;
   pm_state_t        r_state;
   pm_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_run;
   logic [CNT_W-1:0] r_snap;
   logic [CNT_W-1:0] r_cont;
   logic [DW-1:0]    r_deb;
   logic             r_valid;
   logic             r_busy;
   logic             r_ovf;

   logic             w_btn_s;
   logic             w_tick;
   logic             w_restart;
   logic             w_run_en;
   logic             w_deb_en;
   logic             w_deb_clr;
   logic             w_deb_hit;
   logic             w_snap_ld;
   logic             w_publish;
   logic             w_ovf_set;
   logic             w_ovf_clr;
   logic             w_run_at_max;
   logic [CNT_W-1:0] w_run_inc;
   logic [CNT_W-1:0] w_snap_val;

   pulse_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (w_restart),
      .tick    (w_tick)
   );

   assign w_btn_s      = r_sync2;
   assign w_run_at_max = (r_run == CNT_MAX);
   assign w_run_inc    = w_run_at_max ? r_run : r_run + 1'b1;
   assign w_deb_hit    = w_tick && (r_deb == DEB_LAST);
   assign w_deb_clr    = w_restart || w_snap_ld;
   assign w_ovf_clr    = clear || w_restart;
   // the release-edge tick is counted before the snapshot
   assign w_snap_val   = w_run_en ? w_run_inc : r_run;

   // two-flop synchroniser for the asynchronous button
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; the button level wins over debounce completion
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_btn_s) w_state_nxt = ST_DEB_PRESS;
         end
         ST_DEB_PRESS: begin
            if (!w_btn_s)       w_state_nxt = ST_IDLE;
            else if (w_deb_hit) w_state_nxt = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (!w_btn_s) w_state_nxt = ST_DEB_REL;
         end
         ST_DEB_REL: begin
            if (w_btn_s)        w_state_nxt = ST_MEASURE;
            else if (w_deb_hit) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (clear) w_state_nxt = ST_IDLE;
   end

   // FSM outputs: datapath enables decoded from the current state
   always_comb begin
      w_restart = 1'b0;
      w_run_en  = w_tick && pm_is_counting(r_state);
      w_deb_en  = 1'b0;
      w_snap_ld = 1'b0;
      w_publish = 1'b0;
      w_ovf_set = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_restart = w_btn_s && !clear;
         end
         ST_DEB_PRESS: begin
            w_deb_en = w_tick;
         end
         ST_MEASURE: begin
            w_ovf_set = w_tick && w_run_at_max && !clear;
            w_snap_ld = !w_btn_s;
         end
         ST_DEB_REL: begin
            w_deb_en = w_tick;
         end
         ST_DONE: begin
            w_publish = !clear;
         end
         default: begin
            w_restart = 1'b0;
         end
      endcase
   end

   // saturating run counter, zeroed at press entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= '0;
      end else if (w_restart) begin
         r_run <= '0;
      end else if (w_run_en) begin
         r_run <= w_run_inc;
      end
   end

   // debounce tick counter, zeroed at press entry and at release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb <= '0;
      end else if (w_deb_clr) begin
         r_deb <= '0;
      end else if (w_deb_en) begin
         r_deb <= r_deb + 1'b1;
      end
   end

   // candidate result captured on each release edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap <= '0;
      end else if (w_snap_ld) begin
         r_snap <= w_snap_val;
      end
   end

   // published result and its strobe; clear zeroes the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cont  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_publish;
         if (clear) begin
            r_cont <= '0;
         end else if (w_publish) begin
            r_cont <= r_snap;
         end
      end
   end

   // sticky overflow flag, cleared at press entry or by clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_clr) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end
   end

   // busy follows the next state so it rises the cycle after IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != ST_IDLE);
      end
   end

   assign cont_tiempo = r_cont;
   assign meas_valid  = r_valid;
   assign busy        = r_busy;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_pulse_meas_ctrl.sv
// Bench for pulse_meas_ctrl: 15-bit and 4-bit instances on shared stimulus.
// Table vectors, corner sequences and random presses against a tick model.
module tb_pulse_meas_ctrl;

   localparam int TD   = 4;
   localparam int DB   = 2;
   localparam int MX15 = 32767;
   localparam int MX4  = 15;
   localparam int NV   = 8;

   localparam int P_IDLE  = 0;
   localparam int P_PRESS = 1;
   localparam int P_MEAS  = 2;
   localparam int P_REL   = 3;
   localparam int P_DONE  = 4;

   typedef struct packed {
      int ph;
      int age;
      int run;
      int deb;
      int snap;
      int cont;
      bit s1;
      bit s2;
      bit valid;
      bit busy;
      bit ovf;
   } mdl_t;

   typedef struct {
      int hi;
      bit rep;
      int c15;
      int c4;
      bit o4;
   } vec_t;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        btn_in = 1'b0;
   logic        clear  = 1'b0;
   logic [14:0] c15;
   logic        v15, b15, o15;
   logic [3:0]  c4;
   logic        v4, b4, o4;

   int   n_pass = 0;
   int   n_tot  = 0;
   bit   chk_en = 1'b0;
   mdl_t m15;
   mdl_t m4;
   vec_t tv [NV];

   pulse_meas_ctrl #(
      .TICK_DIV       (TD),
      .DEBOUNCE_TICKS (DB),
      .CNT_W          (15)
   ) u_dut15 (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .clear       (clear),
      .cont_tiempo (c15),
      .meas_valid  (v15),
      .busy        (b15),
      .overflow    (o15)
   );

   pulse_meas_ctrl #(
      .TICK_DIV       (TD),
      .DEBOUNCE_TICKS (DB),
      .CNT_W          (4)
   ) u_dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .clear       (clear),
      .cont_tiempo (c4),
      .meas_valid  (v4),
      .busy        (b4),
      .overflow    (o4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
   endtask

   // Reference: ticks fall every TD clocks after press entry.
   function automatic mdl_t step(mdl_t m, logic btn, logic clr, int mx);
      mdl_t n;
      bit   tk;
      bit   bs;
      n       = m;
      bs      = m.s2;
      n.s2    = m.s1;
      n.s1    = btn;
      n.age   = m.age + 1;
      n.valid = 1'b0;
      tk      = ((m.age + 1) % TD) == 0;
      if (clr) begin
         n.ph   = P_IDLE;
         n.cont = 0;
         n.ovf  = 1'b0;
      end else begin
         case (m.ph)
            P_IDLE: if (bs) begin
               n.ph  = P_PRESS;
               n.run = 0;
               n.deb = 0;
               n.age = 0;
               n.ovf = 1'b0;
            end
            P_PRESS: begin
               if (tk) begin
                  n.run = m.run + 1;
                  n.deb = m.deb + 1;
               end
               if (!bs) n.ph = P_IDLE;
               else if (n.deb >= DB) n.ph = P_MEAS;
            end
            P_MEAS: begin
               if (tk) begin
                  if (m.run >= mx) n.ovf = 1'b1;
                  else n.run = m.run + 1;
               end
               if (!bs) begin
                  n.snap = n.run;
                  n.deb  = 0;
                  n.ph   = P_REL;
               end
            end
            P_REL: begin
               if (tk) begin
                  n.run = (m.run >= mx) ? mx : m.run + 1;
                  n.deb = m.deb + 1;
               end
               if (bs) n.ph = P_MEAS;
               else if (n.deb >= DB) n.ph = P_DONE;
            end
            P_DONE: begin
               n.cont  = m.snap;
               n.valid = 1'b1;
               n.ph    = P_IDLE;
            end
            default: n.ph = P_IDLE;
         endcase
      end
      n.busy = (n.ph != P_IDLE);
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m15 <= '0;
         m4  <= '0;
      end else begin
         m15 <= step(m15, btn_in, clear, MX15);
         m4  <= step(m4, btn_in, clear, MX4);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_cont15", c15, m15.cont);
         chk("cyc_valid15", v15, m15.valid);
         chk("cyc_busy15", b15, m15.busy);
         chk("cyc_ovf15", o15, m15.ovf);
         chk("cyc_cont4", c4, m4.cont);
         chk("cyc_valid4", v4, m4.valid);
         chk("cyc_busy4", b4, m4.busy);
         chk("cyc_ovf4", o4, m4.ovf);
      end
   end

   task automatic press(input int h);
      btn_in = 1'b1;
      repeat (h) @(negedge clk);
      btn_in = 1'b0;
   endtask

   // watches lim cycles; reports strobe count and values at the first one
   task automatic watch(input int lim, output int nv, output int lat,
                        output int r15, output int r4, output int ro4);
      nv = 0; lat = 0; r15 = 0; r4 = 0; ro4 = 0;
      for (int k = 1; k <= lim; k++) begin
         @(negedge clk);
         if (v15) begin
            if (nv == 0) begin
               lat = k;
               r15 = int'(c15);
               r4  = int'(c4);
               ro4 = int'(o4);
            end
            nv++;
         end
      end
   endtask

   task automatic wait_idle(input int lim);
      bit ok;
      ok = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 0; k < lim; k++) begin
         if (!b15 && !b4) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("idle_timeout", 0, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int nv, lat, r15, r4, ro4;
      tv[0] = '{40, 1'b1, 10, 10, 1'b0};
      tv[1] = '{ 6, 1'b0, 10, 10, 1'b0};
      tv[2] = '{ 8, 1'b0, 10, 10, 1'b0};
      tv[3] = '{ 9, 1'b1,  2,  2, 1'b0};
      tv[4] = '{63, 1'b1, 15, 15, 1'b0};
      tv[5] = '{64, 1'b1, 16, 15, 1'b1};
      tv[6] = '{80, 1'b1, 20, 15, 1'b1};
      tv[7] = '{16, 1'b1,  4,  4, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_cont", c15, 0);
      chk("rst_valid", v15, 0);
      chk("rst_busy", b15, 0);
      chk("rst_ovf", o15, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         press(tv[i].hi);
         watch(30, nv, lat, r15, r4, ro4);
         if (tv[i].rep) begin
            chk($sformatf("v%0d_strobes", i), nv, 1);
            chk($sformatf("v%0d_lat_le12", i), int'(lat <= 12), 1);
            chk($sformatf("v%0d_cont15", i), r15, tv[i].c15);
            chk($sformatf("v%0d_cont4", i), r4, tv[i].c4);
            chk($sformatf("v%0d_ovf4", i), ro4, int'(tv[i].o4));
         end else begin
            chk($sformatf("v%0d_strobes", i), nv, 0);
            chk($sformatf("v%0d_cont15", i), c15, tv[i].c15);
            chk($sformatf("v%0d_cont4", i), c4, tv[i].c4);
         end
         chk($sformatf("v%0d_ovf15", i), o15, 0);
         wait_idle(100);
      end

      // release bounce
      press(40);
      repeat (4) @(negedge clk);
      press(20);
      watch(40, nv, lat, r15, r4, ro4);
      chk("bounce_strobes", nv, 1);
      chk("bounce_cont15", r15, 16);
      wait_idle(100);

      // clear in the DONE cycle
      press(40);
      repeat (11) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      watch(20, nv, lat, r15, r4, ro4);
      chk("clr_done_strobes", nv, 0);
      chk("clr_done_cont15", c15, 0);
      chk("clr_done_cont4", c4, 0);
      wait_idle(100);

      // clear while held in MEASURE, then re-entry
      btn_in = 1'b1;
      repeat (20) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      chk("clr_meas_busy0", b15, 0);
      clear = 1'b0;
      @(negedge clk);
      chk("clr_meas_busy1", b15, 1);
      repeat (30) @(negedge clk);
      btn_in = 1'b0;
      watch(30, nv, lat, r15, r4, ro4);
      chk("clr_meas_strobes", nv, 1);
      chk("clr_meas_cont15", r15, 8);
      wait_idle(100);

      // asynchronous reset mid-measurement
      btn_in = 1'b1;
      repeat (30) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cont15", c15, 0);
      chk("arst_busy15", b15, 0);
      chk("arst_valid15", v15, 0);
      chk("arst_cont4", c4, 0);
      chk("arst_busy4", b4, 0);
      chk("arst_ovf4", o4, 0);
      repeat (3) @(negedge clk);
      btn_in = 1'b0;
      rst_n  = 1'b1;
      repeat (4) @(negedge clk);

      // random presses, bounces and clears against the model
      for (int it = 0; it < 80; it++) begin
         btn_in = 1'b1;
         repeat ($urandom_range(1, 70)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            btn_in = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            btn_in = 1'b1;
            repeat ($urandom_range(1, 30)) @(negedge clk);
         end
         if ($urandom_range(0, 7) == 0) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            repeat ($urandom_range(1, 10)) @(negedge clk);
         end
         btn_in = 1'b0;
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end
      wait_idle(100);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
